// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: captures decoded fields and operands, detects
// load-use hazards against the instruction in EX, and handles flush/hold.
module id_ex_reg #(
  parameter logic [31:0] NOP_INST = 32'h0000_0013,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] inst_addr_i,
  input  logic [31:0] op1_i,
  input  logic [31:0] op2_i,
  input  logic [31:0] imm_i,
  input  logic [4:0]  rs1_addr_i,
  input  logic [4:0]  rs2_addr_i,
  input  logic        rs1_used_i,
  input  logic        rs2_used_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        reg_wen_i,
  input  logic        mem_ren_i,
  input  logic        mem_wen_i,
  input  logic        flush_i,
  input  logic        hold_i,
  output logic        valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic [31:0] op1_o,
  output logic [31:0] op2_o,
  output logic [31:0] imm_o,
  output logic [4:0]  rd_addr_o,
  output logic        reg_wen_o,
  output logic        mem_ren_o,
  output logic        mem_wen_o,
  output logic        load_use_stall_o
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_addr;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] imm;
    logic [RW-1:0]   rd_addr;
    logic            reg_wen;
    logic            mem_ren;
    logic            mem_wen;
  } ex_t;

  // Bubble contents double as the reset value; enables are always zero.
  localparam ex_t BUBBLE = '{
    valid:     1'b0,
    inst:      NOP_INST,
    inst_addr: RESET_PC,
    op1:       XLEN'(0),
    op2:       XLEN'(0),
    imm:       XLEN'(0),
    rd_addr:   RW'(0),
    reg_wen:   1'b0,
    mem_ren:   1'b0,
    mem_wen:   1'b0
  };

  ex_t  ex_q;
  ex_t  ex_d;
  ex_t  id_c;
  logic rs1_hit_c;
  logic rs2_hit_c;
  logic lu_c;

  // Incoming ID instruction as it would appear in EX.
  always_comb begin
    id_c           = BUBBLE;
    id_c.valid     = 1'b1;
    id_c.inst      = inst_i;
    id_c.inst_addr = inst_addr_i;
    id_c.op1       = op1_i;
    id_c.op2       = op2_i;
    id_c.imm       = imm_i;
    id_c.rd_addr   = rd_addr_i;
    id_c.reg_wen   = reg_wen_i;
    id_c.mem_ren   = mem_ren_i;
    id_c.mem_wen   = mem_wen_i;
  end

  // Load in EX whose non-x0 destination is read by the ID instruction.
  always_comb begin
    rs1_hit_c = rs1_used_i && (rs1_addr_i == ex_q.rd_addr);
    rs2_hit_c = rs2_used_i && (rs2_addr_i == ex_q.rd_addr);
    lu_c      = valid_i && ex_q.valid && ex_q.mem_ren &&
                (ex_q.rd_addr != RW'(0)) && (rs1_hit_c || rs2_hit_c);
  end

  // Flush overrides hold; hold overrides the hazard bubble.
  always_comb begin
    ex_d = ex_q;
    if (flush_i) begin
      ex_d = BUBBLE;
    end else if (hold_i) begin
      ex_d = ex_q;
    end else if (lu_c) begin
      ex_d = BUBBLE;
    end else if (!valid_i) begin
      ex_d = BUBBLE;
    end else begin
      ex_d = id_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q <= BUBBLE;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign load_use_stall_o = lu_c && !flush_i && !hold_i;

  assign valid_o     = ex_q.valid;
  assign inst_o      = ex_q.inst;
  assign inst_addr_o = ex_q.inst_addr;
  assign op1_o       = ex_q.op1;
  assign op2_o       = ex_q.op2;
  assign imm_o       = ex_q.imm;
  assign rd_addr_o   = ex_q.rd_addr;
  assign reg_wen_o   = ex_q.reg_wen;
  assign mem_ren_o   = ex_q.mem_ren;
  assign mem_wen_o   = ex_q.mem_wen;

endmodule
